// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit ALU between two requesters.
// Each port owns a single response slot that is drained by its own valid/ready handshake.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_A,
  input  logic [15:0] req0_B,
  input  logic [6:0]  req0_op,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [15:0] resp0_out,
  output logic        resp0_ovfl,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_A,
  input  logic [15:0] req1_B,
  input  logic [6:0]  req1_op,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [15:0] resp1_out,
  output logic        resp1_ovfl,

  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [6:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic        alu_ovfl
);

  // last = most recently granted port; reset to 1 so port 0 wins the first tie
  logic last;
  logic elig0, elig1;
  logic grant0, grant1;

  // A slot being drained this cycle can take a new operation in the same cycle.
  always_comb begin
    elig0  = req0_valid & (~resp0_valid | resp0_ready);
    elig1  = req1_valid & (~resp1_valid | resp1_ready);
    grant0 = ~rst & elig0 & (~elig1 | last);
    grant1 = ~rst & elig1 & (~elig0 | ~last);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_A  = 16'h0000;
    alu_B  = 16'h0000;
    alu_op = 7'b0000000;
    if (grant0) begin
      alu_A  = req0_A;
      alu_B  = req0_B;
      alu_op = req0_op;
    end else if (grant1) begin
      alu_A  = req1_A;
      alu_B  = req1_B;
      alu_op = req1_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp0_valid <= 1'b0;
      resp0_out   <= 16'h0000;
      resp0_ovfl  <= 1'b0;
    end else if (grant0) begin
      resp0_valid <= 1'b1;
      resp0_out   <= alu_out;
      resp0_ovfl  <= alu_ovfl;
    end else if (resp0_ready) begin
      resp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp1_valid <= 1'b0;
      resp1_out   <= 16'h0000;
      resp1_ovfl  <= 1'b0;
    end else if (grant1) begin
      resp1_valid <= 1'b1;
      resp1_out   <= alu_out;
      resp1_ovfl  <= alu_ovfl;
    end else if (resp1_ready) begin
      resp1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= 1'b1;
    else if (grant0)
      last <= 1'b0;
    else if (grant1)
      last <= 1'b1;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU stub, transaction-level reference model, directed and random scenarios.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rq_valid [2];
  logic        rq_ready [2];
  logic [15:0] rq_A     [2];
  logic [15:0] rq_B     [2];
  logic [6:0]  rq_op    [2];
  logic        rs_valid [2];
  logic        rs_ready [2];
  logic [15:0] rs_out   [2];
  logic        rs_ovfl  [2];
  logic [15:0] alu_A, alu_B, alu_out;
  logic [6:0]  alu_op;
  logic        alu_ovfl;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: per-port slot contents and the last granted port
  bit          m_valid [2];
  logic [15:0] m_out   [2];
  bit          m_ovfl  [2];
  int          m_last;
  bit          m_granted [2];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(rq_valid[0]), .req0_ready(rq_ready[0]), .req0_A(rq_A[0]), .req0_B(rq_B[0]),
    .req0_op(rq_op[0]), .resp0_valid(rs_valid[0]), .resp0_ready(rs_ready[0]),
    .resp0_out(rs_out[0]), .resp0_ovfl(rs_ovfl[0]),
    .req1_valid(rq_valid[1]), .req1_ready(rq_ready[1]), .req1_A(rq_A[1]), .req1_B(rq_B[1]),
    .req1_op(rq_op[1]), .resp1_valid(rs_valid[1]), .resp1_ready(rs_ready[1]),
    .resp1_out(rs_out[1]), .resp1_ovfl(rs_ovfl[1]),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_out(alu_out), .alu_ovfl(alu_ovfl)
  );

  // ALU stub: op[6:5] selects add / xor / and / pass-B; pass-B reports op[4] as overflow
  function automatic logic [16:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [6:0] op);
    logic [15:0] s;
    case (op[6:5])
      2'b00: begin
        s = a + b;
        return {(a[15] == b[15]) && (s[15] != a[15]), s};
      end
      2'b01:   return {1'b0, a ^ b};
      2'b10:   return {1'b0, a & b};
      default: return {op[4], b};
    endcase
  endfunction

  always_comb {alu_ovfl, alu_out} = alu_ref(alu_A, alu_B, alu_op);

  // Expected winner this cycle: a port may issue when it has a request and its slot is free
  // or being drained; a tie goes to whichever port was not served most recently.
  function automatic logic [1:0] predict_grant();
    bit e0, e1;
    e0 = rq_valid[0] && (!m_valid[0] || rs_ready[0]);
    e1 = rq_valid[1] && (!m_valid[1] || rs_ready[1]);
    if (rst) return 2'b00;
    if (e0 && e1) return (m_last == 1) ? 2'b01 : 2'b10;
    return {e1, e0};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_valid[p] = 0; m_out[p] = 16'h0000; m_ovfl[p] = 0; m_granted[p] = 0;
    end
    m_last = 1;
  endtask

  // advance one clock edge and update the model with what happened at it
  task automatic tick();
    logic [1:0] g;
    logic [16:0] r;
    @(posedge clk);
    g = predict_grant();
    if (rst) model_reset();
    else begin
      for (int p = 0; p < 2; p++) begin
        m_granted[p] = g[p];
        if (g[p]) begin
          r = alu_ref(rq_A[p], rq_B[p], rq_op[p]);
          m_valid[p] = 1; m_out[p] = r[15:0]; m_ovfl[p] = r[16]; m_last = p;
        end else if (rs_ready[p]) m_valid[p] = 0;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_op(input int p);
    rq_A[p]  = 16'($urandom);
    rq_B[p]  = 16'($urandom);
    rq_op[p] = 7'($urandom);
  endtask

  task automatic test_reset();
    rq_valid[0] = 1; rq_valid[1] = 1;
    rand_op(0); rand_op(1);
    #2;
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (rs_valid[p] !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid%0d got %b want 0", p, rs_valid[p]); end
      n_checks++;
      if (rs_out[p] !== 16'h0000) begin n_fail++; $display("FAIL reset_resp_out%0d got %h want 0000", p, rs_out[p]); end
      n_checks++;
      if (rs_ovfl[p] !== 1'b0) begin n_fail++; $display("FAIL reset_resp_ovfl%0d got %b want 0", p, rs_ovfl[p]); end
      n_checks++;
      if (rq_ready[p] !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready%0d got %b want 0", p, rq_ready[p]); end
    end
    n_checks++;
    if ({alu_A, alu_B, alu_op} !== 39'd0) begin
      n_fail++; $display("FAIL reset_alu_idle got %h/%h/%h want zeros", alu_A, alu_B, alu_op);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rq_ready[1], rq_ready[0]} !== 2'b01) begin
      n_fail++; $display("FAIL reset_first_tie got %b%b want 01", rq_ready[1], rq_ready[0]);
    end
    tick();
    rq_valid[0] = 0; rq_valid[1] = 0;
  endtask

  task automatic test_single();
    rq_valid[0] = 1; rq_A[0] = 16'h00FF; rq_B[0] = 16'h0F0F; rq_op[0] = 7'b0100000;
    @(negedge clk);
    n_checks++;
    if (rq_ready[0] !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", rq_ready[0]); end
    n_checks++;
    if ({alu_A, alu_B, alu_op} !== {16'h00FF, 16'h0F0F, 7'b0100000}) begin
      n_fail++; $display("FAIL single_alu_drive got %h/%h/%h want 00ff/0f0f/20", alu_A, alu_B, alu_op);
    end
    tick();
    rq_valid[0] = 0;
    @(negedge clk);
    n_checks++;
    if (rs_valid[0] !== 1'b1 || rs_out[0] !== 16'h0FF0) begin
      n_fail++; $display("FAIL single_resp got v=%b %h want v=1 0ff0", rs_valid[0], rs_out[0]);
    end
    n_checks++;
    if (rq_ready[1] !== 1'b0 || rs_valid[1] !== 1'b0) begin
      n_fail++; $display("FAIL single_port1_idle got ready=%b valid=%b want 0 0", rq_ready[1], rs_valid[1]);
    end
    n_checks++;
    if ({alu_A, alu_B, alu_op} !== 39'd0) begin
      n_fail++; $display("FAIL single_alu_idle got %h/%h/%h want zeros", alu_A, alu_B, alu_op);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [16:0] exp_r;
    int prev;
    apply_reset();
    rs_ready[0] = 1; rs_ready[1] = 1;
    rq_valid[0] = 1; rq_valid[1] = 1;
    rand_op(0); rand_op(1);
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (rq_ready[i % 2] !== 1'b1 || rq_ready[1 - i % 2] !== 1'b0) begin
        n_fail++; $display("FAIL contention_order cycle %0d got %b%b want port %0d", i, rq_ready[1], rq_ready[0], i % 2);
      end
      if (prev >= 0) begin
        n_checks++;
        if (rs_valid[prev] !== 1'b1 || {rs_ovfl[prev], rs_out[prev]} !== exp_r) begin
          n_fail++; $display("FAIL contention_resp%0d got %b%h want %h", prev, rs_ovfl[prev], rs_out[prev], exp_r);
        end
      end
      exp_r = alu_ref(rq_A[i % 2], rq_B[i % 2], rq_op[i % 2]);
      prev = i % 2;
      tick();
      rand_op(i % 2);
    end
    rq_valid[0] = 0; rq_valid[1] = 0;
    @(negedge clk);
    n_checks++;
    if (rs_valid[1] !== 1'b1 || {rs_ovfl[1], rs_out[1]} !== exp_r) begin
      n_fail++; $display("FAIL contention_last_resp got %b%h want %h", rs_ovfl[1], rs_out[1], exp_r);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    rs_ready[0] = 0; rs_ready[1] = 1;
    rq_valid[0] = 1; rand_op(0);
    tick();
    held = m_out[0];
    rand_op(0);
    rq_valid[1] = 1; rand_op(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (rq_ready[0] !== 1'b0 || rq_ready[1] !== 1'b1) begin
        n_fail++; $display("FAIL backpressure_stream cycle %0d got r0=%b r1=%b want 0 1", i, rq_ready[0], rq_ready[1]);
      end
      n_checks++;
      if (rs_valid[0] !== 1'b1 || rs_out[0] !== held) begin
        n_fail++; $display("FAIL backpressure_hold got v=%b %h want v=1 %h", rs_valid[0], rs_out[0], held);
      end
      tick();
      rand_op(1);
    end
    rs_ready[0] = 1;
    @(negedge clk);
    n_checks++;
    if (rq_ready[0] !== 1'b1 || rq_ready[1] !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_release got r0=%b r1=%b want 1 0", rq_ready[0], rq_ready[1]);
    end
    tick();
    rq_valid[0] = 0; rq_valid[1] = 0;
    tick();
  endtask

  task automatic test_refill();
    rs_ready[0] = 0;
    rq_valid[0] = 1; rq_A[0] = 16'($urandom); rq_B[0] = 16'h1111; rq_op[0] = 7'b1100000;
    tick();
    rq_B[0] = 16'h2222; rs_ready[0] = 1;
    @(negedge clk);
    n_checks++;
    if (rq_ready[0] !== 1'b1 || rs_valid[0] !== 1'b1 || rs_out[0] !== 16'h1111) begin
      n_fail++; $display("FAIL refill_same_cycle got r=%b v=%b %h want 1 1 1111", rq_ready[0], rs_valid[0], rs_out[0]);
    end
    tick();
    rq_valid[0] = 0;
    @(negedge clk);
    n_checks++;
    if (rs_valid[0] !== 1'b1 || rs_out[0] !== 16'h2222) begin
      n_fail++; $display("FAIL refill_new_data got v=%b %h want 1 2222", rs_valid[0], rs_out[0]);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [15:0] keep_out;
    bit keep_valid, keep_ovfl;
    rs_ready[0] = 0;
    rq_valid[0] = 1; rq_A[0] = 16'h0001; rq_B[0] = 16'h0002; rq_op[0] = 7'b0000000;
    tick();
    rq_valid[0] = 0;
    keep_out = m_out[0]; keep_valid = m_valid[0]; keep_ovfl = m_ovfl[0];
    rq_valid[1] = 1; rq_A[1] = 16'($urandom); rq_B[1] = 16'h7FFF; rq_op[1] = 7'b1110000;
    tick();
    rq_valid[1] = 0;
    @(negedge clk);
    n_checks++;
    if (rs_valid[1] !== 1'b1 || rs_ovfl[1] !== 1'b1 || rs_out[1] !== 16'h7FFF) begin
      n_fail++; $display("FAIL overflow_capture got v=%b o=%b %h want 1 1 7fff", rs_valid[1], rs_ovfl[1], rs_out[1]);
    end
    n_checks++;
    if (rs_valid[0] !== keep_valid || rs_out[0] !== keep_out || rs_ovfl[0] !== keep_ovfl || keep_out !== 16'h0003) begin
      n_fail++; $display("FAIL overflow_port0_untouched got v=%b o=%b %h want 1 0 0003", rs_valid[0], rs_ovfl[0], rs_out[0]);
    end
    rs_ready[0] = 1;
    tick();
  endtask

  task automatic test_async_reset();
    rs_ready[0] = 0; rs_ready[1] = 0;
    rq_valid[0] = 1; rand_op(0);
    tick();
    rq_valid[0] = 0; rq_valid[1] = 1; rand_op(1);
    tick();
    rq_valid[1] = 0;
    #2;
    n_checks++;
    if (rs_valid[0] !== 1'b1 || rs_valid[1] !== 1'b1) begin
      n_fail++; $display("FAIL async_prefill got %b%b want 11", rs_valid[1], rs_valid[0]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (rs_valid[0] !== 1'b0 || rs_valid[1] !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_clear got %b%b want 00", rs_valid[1], rs_valid[0]);
    end
    n_checks++;
    if (rs_out[0] !== 16'h0000 || rs_out[1] !== 16'h0000) begin
      n_fail++; $display("FAIL async_reset_data got %h %h want 0000 0000", rs_out[0], rs_out[1]);
    end
    rq_valid[0] = 1; rq_valid[1] = 1; rs_ready[0] = 1; rs_ready[1] = 1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rq_ready[0] !== 1'b1 || rq_ready[1] !== 1'b0) begin
      n_fail++; $display("FAIL async_first_tie got r0=%b r1=%b want 1 0", rq_ready[0], rq_ready[1]);
    end
    tick();
    rq_valid[0] = 0; rq_valid[1] = 0;
    tick();
  endtask

  task automatic test_random();
    logic [1:0] g;
    logic [38:0] exp_alu;
    for (int c = 0; c < 500; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq_valid[p] || m_granted[p]) begin
          rq_valid[p] = ($urandom_range(0, 9) < 7);
          rand_op(p);
        end
        rs_ready[p] = ($urandom_range(0, 9) < 6);
      end
      @(negedge clk);
      g = predict_grant();
      exp_alu = 39'd0;
      for (int p = 0; p < 2; p++) if (g[p]) exp_alu = {rq_A[p], rq_B[p], rq_op[p]};
      n_checks++;
      if ({rq_ready[1], rq_ready[0]} !== g) begin
        n_fail++; $display("FAIL random_grant cycle %0d got %b%b want %b", c, rq_ready[1], rq_ready[0], g);
      end
      n_checks++;
      if ({alu_A, alu_B, alu_op} !== exp_alu) begin
        n_fail++; $display("FAIL random_alu cycle %0d got %h/%h/%h want %h", c, alu_A, alu_B, alu_op, exp_alu);
      end
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (rs_valid[p] !== m_valid[p]) begin
          n_fail++; $display("FAIL random_resp_valid%0d cycle %0d got %b want %b", p, c, rs_valid[p], m_valid[p]);
        end
        if (m_valid[p]) begin
          n_checks++;
          if (rs_out[p] !== m_out[p] || rs_ovfl[p] !== m_ovfl[p]) begin
            n_fail++; $display("FAIL random_resp_data%0d cycle %0d got %b%h want %b%h", p, c, rs_ovfl[p], rs_out[p], m_ovfl[p], m_out[p]);
          end
        end
      end
      tick();
    end
    rq_valid[0] = 0; rq_valid[1] = 0;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      rq_valid[p] = 0; rq_A[p] = 0; rq_B[p] = 0; rq_op[p] = 0; rs_ready[p] = 1;
    end
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_refill();
    test_overflow();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
